// File: rtl/conv_ctrl_pkg.sv
// Shared constants and state encoding for the convolution sequencer.
// CONV_ZERO_PAD_EN selects the zero-padded "same" 4x4 output variant.
package conv_ctrl_pkg;

    localparam int IMG_DIM  = 4;
    localparam int KER_DIM  = 3;
    localparam int KER_TAPS = 9;
`ifdef CONV_ZERO_PAD_EN
    localparam int OUT_DIM  = 4;
`else
    localparam int OUT_DIM  = IMG_DIM - KER_DIM + 1;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_WRITE,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/conv_tap_step_counter.sv
// Kernel tap stepper: row-major 0..8 index with split kernel row/column and terminal flag.
module conv_tap_step_counter
    import conv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] idx,
    output logic [1:0] kr,
    output logic [1:0] kc,
    output logic       last
);

    assign last = (idx == 4'(KER_TAPS - 1));

    // Row and column are tracked alongside the index so no divider is needed.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            idx <= '0;
            kr  <= '0;
            kc  <= '0;
        end else if (en) begin
            idx <= last ? 4'd0 : idx + 4'd1;
            if (kc == 2'(KER_DIM - 1)) begin
                kc <= '0;
                kr <= (kr == 2'(KER_DIM - 1)) ? 2'd0 : kr + 2'd1;
            end else begin
                kc <= kc + 2'd1;
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution pass sequencer: CLEAR, 9-tap ACCUM and WRITE per output pixel, then FINISH.
// Define CONV_ZERO_PAD_EN for the zero-padded 4x4 "same" output.
module conv_seq_ctrl
    import conv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       out_ready,
    output logic [1:0] pix_row,
    output logic [1:0] pix_col,
    output logic       pix_zero,
    output logic [3:0] ker_idx,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       out_we,
    output logic [3:0] out_idx,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic [3:0] tap_idx;
    logic [1:0] tap_kr;
    logic [1:0] tap_kc;
    logic       tap_last;
    logic       pos_last;
    logic       in_accum;

    conv_tap_step_counter u_tap (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == ST_CLEAR),
        .en      (state == ST_ACCUM),
        .idx     (tap_idx),
        .kr      (tap_kr),
        .kc      (tap_kc),
        .last    (tap_last)
    );

    assign pos_last = (out_row == 2'(OUT_DIM - 1)) && (out_col == 2'(OUT_DIM - 1));
    assign in_accum = (state == ST_ACCUM);

    // NOTE: sequential state uses non-blocking assignments only, and reset is sampled
    // on the clock edge so every register (including the strobes) clears together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            out_row <= '0;
            out_col <= '0;
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            out_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        out_row <= '0;
                        out_col <= '0;
                        mac_clr <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state   <= ST_ACCUM;
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b1;
                end
                ST_ACCUM: begin
                    if (tap_last) begin
                        state  <= ST_WRITE;
                        mac_en <= 1'b0;
                        out_we <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    // Position only moves once the sink accepts, so OUT_IDX holds during a stall.
                    if (out_ready) begin
                        out_we <= 1'b0;
                        if (pos_last) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_CLEAR;
                            mac_clr <= 1'b1;
                            if (out_col == 2'(OUT_DIM - 1)) begin
                                out_col <= '0;
                                out_row <= out_row + 2'd1;
                            end else begin
                                out_col <= out_col + 2'd1;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    mac_clr <= 1'b0;
                    mac_en  <= 1'b0;
                    out_we  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign ker_idx = in_accum ? tap_idx : 4'd0;
    assign out_idx = out_we ? 4'(out_row) * 4'(OUT_DIM) + 4'(out_col) : 4'd0;

`ifdef CONV_ZERO_PAD_EN
    logic [2:0] row_sum;
    logic [2:0] col_sum;
    logic [2:0] row_adj;
    logic [2:0] col_adj;
    logic       outside;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        row_sum  = {1'b0, out_row} + {1'b0, tap_kr};
        col_sum  = {1'b0, out_col} + {1'b0, tap_kc};
        row_adj  = row_sum - 3'd1;
        col_adj  = col_sum - 3'd1;
        // A sum of 0 or above IMG_DIM means the shifted tap falls off the image edge.
        outside  = (row_sum == 3'd0) || (row_sum > 3'(IMG_DIM)) ||
                   (col_sum == 3'd0) || (col_sum > 3'(IMG_DIM));
        pix_zero = in_accum && outside;
        pix_row  = (in_accum && !outside) ? row_adj[1:0] : 2'd0;
        pix_col  = (in_accum && !outside) ? col_adj[1:0] : 2'd0;
    end
`else
    assign pix_zero = 1'b0;
    assign pix_row  = in_accum ? out_row + tap_kr : 2'd0;
    assign pix_col  = in_accum ? out_col + tap_kc : 2'd0;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Self-checking bench for conv_seq_ctrl: per-cycle comparison against a loop-nest model of a pass.
module tb_conv_seq_ctrl;

`ifdef CONV_ZERO_PAD_EN
    localparam int OD  = 4;
    localparam int PAD = 1;
`else
    localparam int OD  = 2;
    localparam int PAD = 0;
`endif
    localparam int NPOS = OD * OD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       out_ready;
    logic [1:0] pix_row;
    logic [1:0] pix_col;
    logic       pix_zero;
    logic [3:0] ker_idx;
    logic       mac_clr;
    logic       mac_en;
    logic       out_we;
    logic [3:0] out_idx;
    logic       busy;
    logic       done;

    int vectors    = 0;
    int miscompares = 0;

    conv_seq_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .out_ready (out_ready),
        .pix_row   (pix_row),
        .pix_col   (pix_col),
        .pix_zero  (pix_zero),
        .ker_idx   (ker_idx),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .out_we    (out_we),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    wire [17:0] obs = {busy, done, mac_clr, mac_en, out_we, pix_zero,
                       pix_row, pix_col, ker_idx, out_idx};

    function automatic logic [17:0] pack(bit b, bit d, bit clr, bit en, bit we, bit z,
                                         int r, int c, int k, int o);
        logic [1:0] r2 = 2'(r);
        logic [1:0] c2 = 2'(c);
        logic [3:0] k4 = 4'(k);
        logic [3:0] o4 = 4'(o);
        return {b, d, clr, en, we, z, r2, c2, k4, o4};
    endfunction

    // One full pass from an idle DUT; expectations come from nested loops over
    // output positions and kernel taps. Optional random stalls / START noise.
    task automatic run_pass(input string name, input int stall_pct, input bit noise,
                            input int stall_pos, input int stall_len);
        logic [17:0] exp;
        int r, c, held;
        bit z, rdy;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = noise ? 1'($urandom_range(1)) : 1'b0;
        for (int p = 0; p < NPOS; p++) begin
            exp = pack(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s clear p%0d: got %h expected %h", name, p, obs, exp);
            end
            @(negedge clk);
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            for (int t = 0; t < 9; t++) begin
                r = p / OD + t / 3 - PAD;
                c = p % OD + t % 3 - PAD;
                z = (r < 0) || (r > 3) || (c < 0) || (c > 3);
                if (z) begin
                    r = 0;
                    c = 0;
                end
                exp = pack(1, 0, 0, 1, 0, z, r, c, t, 0);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL %s tap p%0d t%0d: got %h expected %h", name, p, t, obs, exp);
                end
                @(negedge clk);
                start = noise ? 1'($urandom_range(1)) : 1'b0;
            end
            held = 0;
            do begin
                if (p == stall_pos) rdy = (held >= stall_len);
                else                rdy = ($urandom_range(99) >= stall_pct);
                held++;
                out_ready = rdy;
                exp = pack(1, 0, 0, 0, 1, 0, 0, 0, 0, p);
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL %s write p%0d: got %h expected %h", name, p, obs, exp);
                end
                @(negedge clk);
                start = noise ? 1'($urandom_range(1)) : 1'b0;
            end while (!rdy);
            out_ready = 1'b1;
        end
        exp = pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s finish: got %h expected %h", name, obs, exp);
        end
        start = noise;   // START during FINISH must be ignored
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs !== 18'h0) begin
                miscompares++;
                $display("FAIL %s idle_after: got %h expected %h", name, obs, 18'h0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        start     = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, 18'h0);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs, 18'h0);
        end
    endtask

    task automatic test_basic();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_pass("basic", 0, 0, -1, 0);   // START in first cycle after release
    endtask

    task automatic test_stall();
        run_pass("stall", 0, 0, 2, 5);
    endtask

    task automatic test_start_ignore();
        run_pass("start_ignore", 0, 1, -1, 0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (ker_idx !== 4'd4 || mac_en !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_accum_tap: got ker %0d en %b expected ker 4 en 1", ker_idx, mac_en);
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_in_accum: got %h expected %h", obs, 18'h0);
        end
        reset_n = 1'b1;
        run_pass("after_accum_reset", 0, 0, -1, 0);

        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (out_we !== 1'b1 || out_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL stall_write: got we %b idx %0d expected we 1 idx 0", out_we, out_idx);
        end
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_in_write: got %h expected %h", obs, 18'h0);
        end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        run_pass("after_write_reset", 0, 0, -1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_pass("random", 35, 1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignore();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; image 4x4, kernel 3x3 and tap count 9 are fixed package constants.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET_N  input  1  reset, synchronous, active-low.
REQ-004 START  input  1  request one full convolution pass; sampled only in IDLE.
REQ-005 OUT_READY  input  1  result sink accepts OUT_WE this cycle.
REQ-006 PIX_ROW  output  2  image row address of current tap.
REQ-007 PIX_COL  output  2  image column address of current tap.
REQ-008 PIX_ZERO  output  1  current tap lies outside the image; datapath substitutes 0.
REQ-009 KER_IDX  output  4  kernel tap index 0..8, row-major.
REQ-010 MAC_CLR  output  1  clear accumulator.
REQ-011 MAC_EN  output  1  accumulate PIX x KER this cycle.
REQ-012 OUT_WE  output  1  accumulator result valid for write.
REQ-013 OUT_IDX  output  4  output pixel index, row-major.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 DONE  output  1  one-cycle pulse at end of pass.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, ACCUM, WRITE, FINISH.
REQ-017 IDLE: START=1 -> CLEAR with output position 0; START=0 -> stay; all outputs 0.
REQ-018 CLEAR: exactly one cycle; MAC_CLR=1, KER_IDX=0; -> ACCUM.
REQ-019 ACCUM: exactly 9 cycles; MAC_EN=1; KER_IDX steps 0..8; after KER_IDX=8 -> WRITE.
REQ-020 Tap address: kr=KER_IDX/3, kc=KER_IDX%3; PIX_ROW=out_row+kr, PIX_COL=out_col+kc (no padding).
REQ-021 WRITE: OUT_WE=1, OUT_IDX=current position, held stable while OUT_READY=0; OUT_READY=1 -> advance.
REQ-022 Advance: last position -> FINISH; otherwise position+1 -> CLEAR.
REQ-023 FINISH: DONE=1 for one cycle; -> IDLE; a new START accepted the following cycle at the earliest.
REQ-024 START while BUSY=1 SHALL be ignored, with no effect on sequence or counters.
REQ-025 Without stalls, START sampled at edge k: first CLEAR cycle k+1, each position 11 cycles, DONE in cycle k+45.
REQ-026 PIX_ROW, PIX_COL, PIX_ZERO, KER_IDX SHALL be 0 outside ACCUM; OUT_IDX SHALL be 0 outside WRITE.
REQ-027 MAC_CLR, MAC_EN, OUT_WE SHALL be mutually exclusive.

Reset
REQ-028 RESET_N=0 at a clock edge SHALL force IDLE, position 0, KER_IDX 0 and all outputs 0, from any state, including mid-ACCUM or WRITE stall.
REQ-029 START high in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-030 Macro CONV_ZERO_PAD_EN SHALL select zero-padded "same" convolution.
REQ-031 Without CONV_ZERO_PAD_EN: 2x2 output, OUT_IDX 0..3, PIX_ZERO tied 0, DONE at k+45.
REQ-032 With CONV_ZERO_PAD_EN: 4x4 output, OUT_IDX 0..15; row=out_row+kr-1, col=out_col+kc-1; if either is outside 0..3 then PIX_ZERO=1 and PIX_ROW=PIX_COL=0, MAC_EN still 1; DONE at k+177.

Structure
REQ-033 Package conv_ctrl_pkg SHALL hold the state enum and constants IMG_DIM=4, KER_DIM=3, KER_TAPS=9, OUT_DIM (2 or 4 per macro).
REQ-034 Tap stepping SHALL be one sub-module conv_tap_step_counter: 0..8 counter with clear, enable, kr/kc outputs and terminal flag at 8.

Verification
REQ-035 Reset, START=1 at k, OUT_READY=1 -> MAC_CLR at k+1, MAC_EN k+2..k+10, OUT_WE/OUT_IDX=0 at k+11, DONE at k+45 only.
REQ-036 Position 3, KER_IDX=8 -> PIX_ROW=3, PIX_COL=3; position 1, KER_IDX=0 -> PIX_ROW=0, PIX_COL=1.
REQ-037 OUT_READY=0 for 5 cycles in WRITE at position 2 -> OUT_WE=1, OUT_IDX=2 held 5 cycles; DONE delayed to k+50.
REQ-038 START pulsed during ACCUM and during FINISH -> ignored; exactly one DONE per accepted START.
REQ-039 RESET_N=0 during ACCUM (KER_IDX=4) -> next cycle IDLE, all outputs 0; subsequent START gives a full normal pass.
REQ-040 CONV_ZERO_PAD_EN, position 0, KER_IDX=0 -> PIX_ZERO=1; KER_IDX=4 -> PIX_ZERO=0, PIX_ROW=0, PIX_COL=0; DONE at k+177.
